// File: rtl/cnn_spi_pkg.sv
// Shared definitions for the CNN SPI input path: receiver FSM states, SPI mode
// encodings, default frame geometry and the status codes shown on the board LEDs.
package cnn_spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2
    } spi_rx_state_e;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;

    localparam int DEFAULT_FRAME_LEN = 1024;
    localparam int DEFAULT_DATA_W    = 8;

    localparam logic [3:0] LED_STAT_IDLE = 4'd0;
    localparam logic [3:0] LED_STAT_RX   = 4'd1;
    localparam logic [3:0] LED_STAT_DONE = 4'd2;
    localparam logic [3:0] LED_STAT_ERR  = 4'd3;

    // Modes 0 and 3 (CPOL == CPHA) sample on the rising sclk edge.
    function automatic logic spi_sample_on_rise(input int mode);
        return (mode == SPI_MODE0) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI line with registered
// single-cycle rise/fall pulses derived from a history flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain, history flop and registered edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            hist_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[STAGES-1] & hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI-slave frame receiver: oversamples the host bus, assembles DATA_W-bit words
// into sequential buffer writes, flags frame completion/abort and returns a status word on MISO.
module spi_frame_rx
    import cnn_spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FRAME_LEN   = DEFAULT_FRAME_LEN,
    parameter int SPI_MODE    = SPI_MODE0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_slave_sclk,
    input  logic              spi_slave_mosi,
    input  logic              spi_slave_ss,
    output logic              spi_slave_miso,
    input  logic [DATA_W-1:0] tx_status,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int               BIT_W       = $clog2(DATA_W);
    localparam logic             SAMPLE_RISE = spi_sample_on_rise(SPI_MODE);
    localparam logic             CPHA        = (SPI_MODE == SPI_MODE1) || (SPI_MODE == SPI_MODE3);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(FRAME_LEN - 1);

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
    logic sample_s, launch_s, mosi_s;
    logic [DATA_W-1:0] rx_word_s;

    // ss resets to the "selected" level so a reset mid-frame never sees a false falling edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_MODE >= SPI_MODE2)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .async_i(spi_slave_sclk),
        .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .async_i(spi_slave_ss),
        .rise_o(ss_rise_s), .fall_o(ss_fall_s)
    );

    // mosi gets one extra flop so it lines up with the registered sclk edge pulse.
    logic [SYNC_STAGES:0] mosi_q;

    // mosi synchroniser and alignment pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], spi_slave_mosi};
        end
    end

    assign mosi_s    = mosi_q[SYNC_STAGES];
    assign sample_s  = SAMPLE_RISE ? sclk_rise_s : sclk_fall_s;
    assign launch_s  = SAMPLE_RISE ? sclk_fall_s : sclk_rise_s;
    assign rx_word_s = shift_in(rx_q, mosi_s);

    spi_rx_state_e     state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; ss rising takes priority over any sclk edge in the same cycle.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                miso_d     = 1'b0;
                if (ss_fall_s) begin
                    state_d = ACTIVE;
                    tx_d    = tx_status;
                    miso_d  = CPHA ? 1'b0 : first_bit(tx_status);
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    miso_d     = 1'b0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    if ((bit_cnt_q != '0) || (word_cnt_q != '0)) begin
                        state_d     = ABORT;
                        frame_err_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sample_s) begin
                    rx_d = rx_word_s;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_word_s;
                        wr_addr_d = word_cnt_q;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + ADDR_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (launch_s) begin
                    // A launch with no bits received yet starts a new status word.
                    if (bit_cnt_q == '0) begin
                        tx_d   = tx_status;
                        miso_d = first_bit(tx_status);
                    end else begin
                        tx_d   = shift_out(tx_q);
                        miso_d = first_bit(shift_out(tx_q));
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            ABORT: begin
                state_d    = IDLE;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                miso_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ACTIVE);
    end

    assign spi_slave_miso = miso_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
    assign busy           = busy_q;

endmodule
